// File: rtl/arbiter_rr4.sv
// arbiter_rr4: four-way fixed/round-robin arbiter with grant hold and hold-limit preemption
module arbiter_rr4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     gnt_id_q, gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [1:0]     last_id_q, last_id_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]     cand;
    logic [1:0]     win;

    function automatic logic [1:0] pick(input logic [3:0] c, input logic m, input logic [1:0] last);
        logic [1:0] w;
        logic [1:0] idx;
        w = 2'd0;
        if (!m) begin
            for (int i = 0; i < 4; i++) if (c[i]) w = 2'(i);
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = last + 2'(k) + 2'd1;
                if (c[idx]) w = idx;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        last_id_d   = last_id_q;
        hold_cnt_d  = hold_cnt_q;
        cand        = (state_q == IDLE) ? req : (req & ~gnt_q);
        win         = pick(cand, mode, last_id_q);
        if (state_q == IDLE || !req[gnt_id_q] || hold_cnt_q == HOLD_LAST) begin
            if (cand != 4'b0000) begin
                state_d     = GRANT;
                gnt_d       = 4'b0001 << win;
                gnt_id_d    = win;
                gnt_valid_d = 1'b1;
                last_id_d   = win;
                hold_cnt_d  = '0;
            end else if (state_q == GRANT && req[gnt_id_q]) begin
                hold_cnt_d  = '0;
            end else begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_id_d    = 2'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            last_id_q   <= 2'd3;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            last_id_q   <= last_id_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
endmodule
